serial_half_subtractor: RTL and testbench

SERIAL_HALF_SUBTRACTOR -- requirements
Module: serial_half_subtractor

---
 rtl/serial_half_subtractor_if.sv | 25 ++
 rtl/serial_half_subtractor.sv | 86 ++++++++
 tb/tb_serial_half_subtractor.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_half_subtractor_if.sv
// Handshake and result bundle for serial_half_subtractor.
// The driver of start/a/b uses master, the subtractor uses slave.
interface serial_half_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             bit_out;
  logic             bit_valid;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, bit_out, bit_valid
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, bit_out, bit_valid
  );
endinterface

// File: rtl/serial_half_subtractor.sv
// Bit-serial unsigned subtractor: one difference bit per cycle, LSB first,
// WIDTH RUN cycles followed by a one-cycle DONE pulse.
module serial_half_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  serial_half_subtractor_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_q;
  logic             br_q;

  logic a_i;
  logic b_i;
  logic d;
  logic br_next;

  always_comb begin
    a_i     = a_sh[0];
    b_i     = b_sh[0];
    d       = a_i ^ b_i ^ br_q;
    br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br_q);
  end

  // Status outputs decode the state directly, so reset clears them immediately.
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DONE);
  assign bus.bit_valid = (state == S_RUN);
  assign bus.bit_out   = (state == S_RUN) & d;
  assign bus.diff      = diff_q;
  assign bus.borrow    = br_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would let the shift chain race itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      diff_q <= '0;
      br_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            br_q  <= 1'b0;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          diff_q <= {d, diff_q[WIDTH-1:1]};
          br_q   <= br_next;
          // Counter parks on its last value instead of wrapping back to zero.
          if (cnt == CNT_LAST) begin
            state <= S_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_half_subtractor.sv
// Directed and swept checks of serial_half_subtractor at WIDTH=8.
module tb_serial_half_subtractor;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  serial_half_subtractor_if #(.WIDTH(8)) bus ();

  serial_half_subtractor #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits for IDLE, launches one operation, and collects what the DUT shows
  // until done. lat counts negedges after the accepting edge (-1 on timeout).
  task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b,
                        output int lat, output logic [7:0] r_diff,
                        output logic r_br, output logic [7:0] bits,
                        output int vcnt);
    int guard;
    lat = -1; r_diff = '0; r_br = 1'b0; bits = '0; vcnt = 0; guard = 0;
    while (bus.busy !== 1'b0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    bus.a = op_a; bus.b = op_b; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus.bit_valid === 1'b1) begin
        if (vcnt < 8) bits[vcnt] = bus.bit_out;
        vcnt++;
      end
      if (bus.done === 1'b1) begin
        lat = n; r_diff = bus.diff; r_br = bus.borrow;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (bus.busy !== 1'b0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic test_reset();
    int lat;
    lat = -1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.diff, bus.borrow, bus.bit_valid, bus.bit_out} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b diff=%h borrow=%b bv=%b bo=%b, want all 0",
               bus.busy, bus.done, bus.diff, bus.borrow, bus.bit_valid, bus.bit_out);
    end
    rst = 1'b0; bus.start = 1'b1; bus.a = 8'h03; bus.b = 8'h01;
    @(posedge clk);
    #1 bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_accept: busy=%b, want 1", bus.busy);
    end
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin lat = n; break; end
    end
    checks++;
    if (lat !== 9 || bus.diff !== 8'h02 || bus.borrow !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_op: lat=%0d diff=%h borrow=%b, want 9 02 0", lat, bus.diff, bus.borrow);
    end
  endtask

  task automatic test_basic();
    int lat, vcnt;
    logic [7:0] d, bits;
    logic br;
    run_op(8'h05, 8'h04, lat, d, br, bits, vcnt);
    checks++;
    if (vcnt !== 8) begin errors++; $display("FAIL basic_valid_cycles: got %0d want 8", vcnt); end
    checks++;
    if (bits !== 8'h01) begin errors++; $display("FAIL basic_serial_bits: got %b want 00000001 (LSB first)", bits); end
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL basic_latency: got %0d want 9", lat); end
    checks++;
    if (d !== 8'h01 || br !== 1'b0) begin
      errors++; $display("FAIL basic_result: got diff=%h borrow=%b want 01 0", d, br);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.diff !== 8'h01) begin
      errors++; $display("FAIL basic_done_single: done=%b busy=%b diff=%h want 0 0 01", bus.done, bus.busy, bus.diff);
    end
  endtask

  task automatic test_borrow();
    int lat, vcnt;
    logic [7:0] d, bits;
    logic br;
    run_op(8'h04, 8'h05, lat, d, br, bits, vcnt);
    checks++;
    if (lat !== 9 || d !== 8'hFF || br !== 1'b1) begin
      errors++; $display("FAIL borrow_4_5: lat=%0d diff=%h borrow=%b want 9 ff 1", lat, d, br);
    end
    checks++;
    if (bits !== 8'hFF) begin errors++; $display("FAIL borrow_4_5_bits: got %b want 11111111", bits); end
    run_op(8'h00, 8'hFF, lat, d, br, bits, vcnt);
    checks++;
    if (lat !== 9 || d !== 8'h01 || br !== 1'b1) begin
      errors++; $display("FAIL borrow_0_ff: lat=%0d diff=%h borrow=%b want 9 01 1", lat, d, br);
    end
  endtask

  task automatic test_back_to_back();
    int lat, vcnt, dones, exp_n;
    logic [7:0] d, bits;
    logic br;
    run_op(8'hA5, 8'hA5, lat, d, br, bits, vcnt);
    checks++;
    if (lat !== 9 || d !== 8'h00 || br !== 1'b0) begin
      errors++; $display("FAIL equal_a5: lat=%0d diff=%h borrow=%b want 9 00 0", lat, d, br);
    end
    wait_idle();
    // 0x37 - 0x52 = -0x1B -> 0xE5 with borrow
    bus.a = 8'h37; bus.b = 8'h52; bus.start = 1'b1;
    dones = 0;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        exp_n = 9 + 10 * dones;
        checks++;
        if (n !== exp_n || bus.diff !== 8'hE5 || bus.borrow !== 1'b1) begin
          errors++;
          $display("FAIL b2b_pulse%0d: at cycle %0d diff=%h borrow=%b want cycle %0d e5 1",
                   dones, n, bus.diff, bus.borrow, exp_n);
        end
        dones++;
      end
    end
    bus.start = 1'b0;
    checks++;
    if (dones !== 4) begin errors++; $display("FAIL b2b_count: got %0d pulses want 4", dones); end
    wait_idle();
  endtask

  task automatic test_start_ignored();
    int lat, busy_seen;
    lat = -1; busy_seen = 0;
    wait_idle();
    bus.a = 8'h10; bus.b = 8'h01; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 4) begin bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'h00; end
      if (bus.done === 1'b1) begin lat = n; break; end
    end
    checks++;
    if (lat !== 9 || bus.diff !== 8'h0F || bus.borrow !== 1'b0) begin
      errors++; $display("FAIL ignore_start: lat=%0d diff=%h borrow=%b want 9 0f 0", lat, bus.diff, bus.borrow);
    end
    bus.start = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) busy_seen++;
    end
    checks++;
    if (busy_seen !== 0 || bus.diff !== 8'h0F) begin
      errors++; $display("FAIL ignore_no_second_op: busy cycles=%0d diff=%h want 0 0f", busy_seen, bus.diff);
    end
  endtask

  task automatic test_async_reset();
    int lat, vcnt, done_seen;
    logic [7:0] d, bits;
    logic br;
    done_seen = 0;
    wait_idle();
    bus.a = 8'h9C; bus.b = 8'h31; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.diff, bus.borrow, bus.bit_valid, bus.bit_out} !== 13'd0) begin
      errors++;
      $display("FAIL async_reset_outputs: busy=%b done=%b diff=%h borrow=%b bv=%b bo=%b want all 0",
               bus.busy, bus.done, bus.diff, bus.borrow, bus.bit_valid, bus.bit_out);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin errors++; $display("FAIL async_reset_no_done: active cycles=%0d want 0", done_seen); end
    run_op(8'h9C, 8'h31, lat, d, br, bits, vcnt);
    checks++;
    if (lat !== 9 || d !== 8'h6B || br !== 1'b0) begin
      errors++; $display("FAIL async_reset_recover: lat=%0d diff=%h borrow=%b want 9 6b 0", lat, d, br);
    end
  endtask

  task automatic test_random_sweep();
    int lat, vcnt;
    logic [7:0] sa, sb, d, bits;
    logic br;
    logic [8:0] expv;
    for (int i = 0; i < 1000; i++) begin
      sa = 8'($urandom_range(0, 255));
      sb = 8'($urandom_range(0, 255));
      expv = {1'b0, sa} - {1'b0, sb};
      run_op(sa, sb, lat, d, br, bits, vcnt);
      checks++;
      if ({br, d} !== expv) begin
        errors++; $display("FAIL sweep_result: a=%h b=%h got %h want %h", sa, sb, {br, d}, expv);
      end
      checks++;
      if (lat !== 9) begin
        errors++; $display("FAIL sweep_latency: a=%h b=%h got %0d want 9", sa, sb, lat);
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0;
    test_reset();
    test_basic();
    test_borrow();
    test_back_to_back();
    test_start_ignored();
    test_async_reset();
    test_random_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
